pwm_fsm: RTL and testbench

- Fixed-duty PWM generator driven by a 1 ms tick clock (clk1ms).
- A 2-bit Moore state machine alternates between an ON phase and an OFF phase. A 26-bit phase counter times each phase.
- The current state, next state and counter are exported for debug and for observation by the bench.
- Sits at the leaf level, driving an LED, motor enable or similar single-bit load.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_phase_counter.sv | 33 +++
 rtl/pwm_fsm.sv | 77 +++++++
 tb/tb_pwm_fsm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the fixed-duty PWM generator: state encodings,
// phase-counter width and a parameter legality helper.
package pwm_pkg;

  localparam int CNT_W = 26;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    OFF  = 2'b10,
    BAD  = 2'b11
  } state_t;

  // A phase length must be at least one tick and must fit the counter.
  function automatic bit ticksLegal(input int unsigned ticks);
    return (ticks != 0) && (ticks < (32'd1 << CNT_W));
  endfunction

endpackage

// File: rtl/pwm_phase_counter.sv
// Phase timer: clears or increments each tick and flags the last tick of
// the phase whose length is presented on i_limit.
module pwm_phase_counter
  import pwm_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_terminal
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Limits are at least one, so limit-1 never underflows.
  assign w_last     = i_limit - CNT_W'(1);
  assign o_terminal = (r_count == w_last);
  assign o_count    = r_count;

endmodule

// File: rtl/pwm_fsm.sv
// Fixed-duty PWM generator: IDLE -> ON/OFF alternation timed by a phase
// counter, with the PWM output registered alongside the state.
module pwm_fsm
  import pwm_pkg::*;
#(
  parameter int unsigned ON_TICKS  = 3,
  parameter int unsigned OFF_TICKS = 7
) (
  input  logic             clk1ms,
  input  logic             reset,
  output logic             PWM,
  output logic [1:0]       nextState,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] counter
);

  if (!ticksLegal(ON_TICKS)) begin : g_bad_on_ticks
    $error("pwm_fsm: ON_TICKS must be in 1 .. 2^26-1");
  end
  if (!ticksLegal(OFF_TICKS)) begin : g_bad_off_ticks
    $error("pwm_fsm: OFF_TICKS must be in 1 .. 2^26-1");
  end

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_TICKS);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_TICKS);

  state_t           r_state;
  state_t           w_next;
  logic             r_pwm;
  logic             w_clear;
  logic             w_inc;
  logic             w_terminal;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_count;

  assign w_limit = (r_state == ON) ? ON_LIM : OFF_LIM;

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = ON;
      ON:      w_next = w_terminal ? OFF : ON;
      OFF:     w_next = w_terminal ? ON : OFF;
      default: w_next = IDLE;
    endcase
  end

  // Outside ON/OFF the counter is held at zero, so every phase starts fresh.
  assign w_clear = ((r_state != ON) && (r_state != OFF)) || w_terminal;
  assign w_inc   = !w_clear;

  pwm_phase_counter u_phase_counter (
    .i_clk      (clk1ms),
    .i_rst_n    (reset),
    .i_clear    (w_clear),
    .i_inc      (w_inc),
    .i_limit    (w_limit),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk1ms or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pwm   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pwm   <= (w_next == ON);
    end
  end

  assign state     = r_state;
  assign nextState = w_next;
  assign PWM       = r_pwm;
  assign counter   = w_count;

endmodule

// File: tb/tb_pwm_fsm.sv
// Directed bench for pwm_fsm: default 3/7 duty plus the 1/1 and 1/1000
// parameter corners, each on its own instance and reset.
module tb_pwm_fsm;
  import pwm_pkg::*;

  logic        clk1ms = 1'b0;
  logic        rstA = 1'b0;
  logic        rstB = 1'b0;
  logic        rstC = 1'b0;

  logic        pwmA, pwmB, pwmC;
  logic [1:0]  nextA, nextB, nextC;
  logic [1:0]  stateA, stateB, stateC;
  logic [25:0] counterA, counterB, counterC;

  int checks = 0;
  int errors = 0;
  int edgeA  = 0;

  always #5 clk1ms = ~clk1ms;

  pwm_fsm #(.ON_TICKS(3), .OFF_TICKS(7)) dut (
    .clk1ms(clk1ms), .reset(rstA), .PWM(pwmA),
    .nextState(nextA), .state(stateA), .counter(counterA)
  );

  pwm_fsm #(.ON_TICKS(1), .OFF_TICKS(1)) dut11 (
    .clk1ms(clk1ms), .reset(rstB), .PWM(pwmB),
    .nextState(nextB), .state(stateB), .counter(counterB)
  );

  pwm_fsm #(.ON_TICKS(1), .OFF_TICKS(1000)) dut1k (
    .clk1ms(clk1ms), .reset(rstC), .PWM(pwmC),
    .nextState(nextC), .state(stateC), .counter(counterC)
  );

  task automatic test_reset();
    repeat (10) begin
      @(negedge clk1ms);
      checks++;
      if (stateA !== 2'b00) begin
        errors++; $display("[TB] FAIL reset_state got %b expected 00", stateA);
      end
      checks++;
      if (counterA !== 26'd0) begin
        errors++; $display("[TB] FAIL reset_counter got %0d expected 0", counterA);
      end
      checks++;
      if (pwmA !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_pwm got %b expected 0", pwmA);
      end
      checks++;
      if (nextA !== 2'b01) begin
        errors++; $display("[TB] FAIL reset_next got %b expected 01", nextA);
      end
    end
  endtask

  // Release reset on a falling edge and expect a full 3-tick ON phase.
  task automatic test_startup(input string tag);
    logic [1:0] expState [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    int         expCnt   [4] = '{0, 1, 2, 0};
    logic       expPwm   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk1ms);
    rstA = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk1ms); #1;
      checks++;
      if (stateA !== expState[i]) begin
        errors++; $display("[TB] FAIL %s_state edge %0d got %b expected %b", tag, i + 1, stateA, expState[i]);
      end
      checks++;
      if (counterA !== 26'(expCnt[i])) begin
        errors++; $display("[TB] FAIL %s_counter edge %0d got %0d expected %0d", tag, i + 1, counterA, expCnt[i]);
      end
      checks++;
      if (pwmA !== expPwm[i]) begin
        errors++; $display("[TB] FAIL %s_pwm edge %0d got %b expected %b", tag, i + 1, pwmA, expPwm[i]);
      end
    end
    edgeA = 4;
  endtask

  task automatic test_periodicity();
    logic [1:0] prevNext;
    int pos, expCnt, onPeak, offPeak, highs;
    logic expPwm;
    onPeak = 0; offPeak = 0; highs = 0;
    repeat (50) begin
      @(negedge clk1ms);
      prevNext = nextA;
      @(posedge clk1ms); #1;
      edgeA++;
      pos    = (edgeA - 1) % 10;
      expPwm = (pos < 3);
      expCnt = (pos < 3) ? pos : pos - 3;
      if (pwmA === 1'b1) highs++;
      if (stateA == 2'b01 && int'(counterA) > onPeak) onPeak = int'(counterA);
      if (stateA == 2'b10 && int'(counterA) > offPeak) offPeak = int'(counterA);
      checks++;
      if (stateA !== prevNext) begin
        errors++; $display("[TB] FAIL period_next edge %0d got %b expected %b", edgeA, stateA, prevNext);
      end
      checks++;
      if (pwmA !== expPwm) begin
        errors++; $display("[TB] FAIL period_pwm edge %0d got %b expected %b", edgeA, pwmA, expPwm);
      end
      checks++;
      if (counterA !== 26'(expCnt)) begin
        errors++; $display("[TB] FAIL period_counter edge %0d got %0d expected %0d", edgeA, counterA, expCnt);
      end
    end
    checks++;
    if (onPeak != 2) begin
      errors++; $display("[TB] FAIL period_on_peak got %0d expected 2", onPeak);
    end
    checks++;
    if (offPeak != 6) begin
      errors++; $display("[TB] FAIL period_off_peak got %0d expected 6", offPeak);
    end
    checks++;
    if (highs != 15) begin
      errors++; $display("[TB] FAIL period_high_count got %0d expected 15", highs);
    end
  endtask

  // Reach OFF with counter 4, then pull reset low between clock edges.
  task automatic test_midreset();
    for (int i = 0; i < 10 && ((edgeA - 1) % 10) != 7; i++) begin
      @(posedge clk1ms); #1;
      edgeA++;
    end
    checks++;
    if (stateA !== 2'b10 || counterA !== 26'd4) begin
      errors++; $display("[TB] FAIL midreset_setup got state %b counter %0d expected 10 and 4", stateA, counterA);
    end
    @(negedge clk1ms);
    #1 rstA = 1'b0;
    #1;
    checks++;
    if (stateA !== 2'b00 || counterA !== 26'd0 || pwmA !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_async got state %b counter %0d pwm %b expected 00 0 0", stateA, counterA, pwmA);
    end
    @(negedge clk1ms);
    test_startup("midreset");
  endtask

  task automatic test_illegal();
    @(negedge clk1ms);
    force dut.r_state = state_t'(2'b11);
    #1;
    checks++;
    if (nextA !== 2'b00) begin
      errors++; $display("[TB] FAIL illegal_next got %b expected 00", nextA);
    end
    #1 release dut.r_state;
    @(posedge clk1ms); #1;
    checks++;
    if (stateA !== 2'b00 || counterA !== 26'd0 || pwmA !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_recover got state %b counter %0d pwm %b expected 00 0 0", stateA, counterA, pwmA);
    end
    @(posedge clk1ms); #1;
    checks++;
    if (stateA !== 2'b01 || counterA !== 26'd0 || pwmA !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_restart got state %b counter %0d pwm %b expected 01 0 1", stateA, counterA, pwmA);
    end
  endtask

  task automatic test_corner_1_1();
    logic expPwm;
    @(negedge clk1ms);
    checks++;
    if (stateB !== 2'b00 || pwmB !== 1'b0) begin
      errors++; $display("[TB] FAIL c11_reset got state %b pwm %b expected 00 0", stateB, pwmB);
    end
    rstB = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk1ms); #1;
      expPwm = ((i % 2) == 0);
      checks++;
      if (pwmB !== expPwm || stateB !== (expPwm ? 2'b01 : 2'b10) || counterB !== 26'd0) begin
        errors++; $display("[TB] FAIL c11_toggle edge %0d got pwm %b state %b counter %0d expected pwm %b counter 0",
                           i + 1, pwmB, stateB, counterB, expPwm);
      end
    end
  endtask

  task automatic test_corner_1_1000();
    int maxCnt;
    maxCnt = 0;
    @(negedge clk1ms);
    rstC = 1'b1;
    for (int i = 1; i <= 1002; i++) begin
      @(posedge clk1ms); #1;
      if (int'(counterC) > maxCnt) maxCnt = int'(counterC);
      if (i == 1) begin
        checks++;
        if (stateC !== 2'b01 || pwmC !== 1'b1) begin
          errors++; $display("[TB] FAIL c1k_first_on got state %b pwm %b expected 01 1", stateC, pwmC);
        end
      end
      if (i == 1001) begin
        checks++;
        if (stateC !== 2'b10 || counterC !== 26'd999) begin
          errors++; $display("[TB] FAIL c1k_off_end got state %b counter %0d expected 10 999", stateC, counterC);
        end
      end
      if (i == 1002) begin
        checks++;
        if (stateC !== 2'b01 || counterC !== 26'd0 || pwmC !== 1'b1) begin
          errors++; $display("[TB] FAIL c1k_wrap got state %b counter %0d pwm %b expected 01 0 1", stateC, counterC, pwmC);
        end
      end
    end
    checks++;
    if (maxCnt != 999) begin
      errors++; $display("[TB] FAIL c1k_max_counter got %0d expected 999", maxCnt);
    end
  endtask

  initial begin
    test_reset();
    test_startup("startup");
    test_periodicity();
    test_midreset();
    test_illegal();
    test_corner_1_1();
    test_corner_1_1000();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
